uart_tx_arbiter: RTL

- Shares the single UART transmitter (byte interface: start pulse, 8-bit data, busy) between NUM_REQ byte-stream requesters, e.g. the hex debug sender, the IDE status reporter and the command echo.
- Round-robin arbitration with message locking: once granted, a requester keeps the transmitter until it drops req, so its multi-character messages are never interleaved.
- A watchdog revokes grants held by stalled owners.
- Sits between the requesters and the UART TX core.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_select.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Used by the transmitter arbiter and its bench.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    DRAIN
  } arb_state_e;

  localparam int UART_BYTE_W = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set bit of req at or
// after ptr, wrapping modulo N. One-hot pick, index and valid.
module rr_select #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          valid
);

  typedef logic [PW:0] sum_t;

  sum_t pos;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = sum_t'(ptr) + sum_t'(k);
      if (pos >= sum_t'(N)) begin
        pos = pos - sum_t'(N);
      end
      if (!valid && req[pos[PW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[PW-1:0];
        pick[pos[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between byte-stream requesters with
// round-robin, message locking and a stalled-owner watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_start,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             req_busy,
  output logic                           uart_tx_start,
  output logic [UART_BYTE_W-1:0]         uart_tx_data,
  input  logic                           uart_tx_busy,
  output logic                           timeout_evt
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [PW:0]   sum_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t TO = cnt_t'(TIMEOUT_CYCLES);

  arb_state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] own_q, own_d;
  cnt_t cnt_q, cnt_d, cnt_inc;
  logic start_q, start_d;
  logic evt_q, evt_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;

  logic [NUM_REQ-1:0] cand, pick;
  logic [PW-1:0] pick_idx;
  logic pick_vld, accept;
  sum_t own_sum;

  // Revoked requesters stay out of the scan until they drop req.
  assign cand = req & ~mask_q;

  rr_select #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req   (cand),
    .ptr   (ptr_q),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign grant         = grant_q;
  assign uart_tx_start = start_q;
  assign uart_tx_data  = data_q;
  assign timeout_evt   = evt_q;

  assign req_busy = ~grant_q
                  | {NUM_REQ{uart_tx_busy | start_q}};

  assign accept  = req_start[own_q] & ~req_busy[own_q];
  assign cnt_inc = (cnt_q == TO) ? cnt_q
                                 : cnt_q + cnt_t'(1);
  assign own_sum = sum_t'(own_q) + sum_t'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q & req;
    start_d = 1'b0;
    evt_d   = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          own_d   = pick_idx;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (accept) begin
          start_d = 1'b1;
          data_d  = req_data[{own_q, 3'b000} +: UART_BYTE_W];
          cnt_d   = '0;
        end
        if (!req[own_q]) begin
          state_d = DRAIN;
        end else if (!accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO) begin
            mask_d[own_q] = 1'b1;
            evt_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Hold grant until the last byte has left the core.
        if (!start_q && !uart_tx_busy) begin
          grant_d = '0;
          ptr_d   = (own_sum >= sum_t'(NUM_REQ)) ? '0
                                                 : own_sum[PW-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      evt_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      evt_q   <= evt_d;
      data_q  <= data_d;
    end
  end

endmodule
